keypad_scan_debounce: RTL and testbench
=======================================

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 12000, hwclk cycles each row is driven (1 ms at 12 MHz); legal values are 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 20, consecutive identical scan frames needed to accept a press or a release; legal values are 1 to 255.
REQ-003 SHALL have port hwclk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-005 SHALL have ports keypad_r1, keypad_r2, keypad_r3, outputs, 1 bit each, one-hot active-high row drives.
REQ-006 SHALL have ports keypad_c1, keypad_c2, keypad_c3, inputs, 1 bit each, asynchronous active-high column senses.
REQ-007 SHALL have port button, output, 4 bits, code of the last accepted key: 0 means none since reset, 1 to 9 identify a key.
REQ-008 SHALL have port bstate, output, 1 bit, a single-cycle strobe marking each accepted press.
REQ-009 SHALL have port held, output, 1 bit, high while the accepted key is considered pressed.

Function
REQ-010 SHALL pass each column input through a 2-flop synchronizer before any use.
REQ-011 SHALL drive rows in the order r1, r2, r3, r1, and so on, each for exactly SCAN_TICKS cycles, with exactly one row high in every cycle.
REQ-012 SHALL sample the synchronized columns on the last cycle of each row dwell.
REQ-013 SHALL define a frame as three consecutive dwells starting at r1, and SHALL evaluate the frame on the r3 sample cycle.
REQ-014 SHALL compute the frame code from row r (1 to 3) and column c (1 to 3) as (r-1)*3+c when exactly one switch is closed in the frame.
REQ-015 SHALL set the frame code to 0 when no switch is closed, and to 15 when more than one switch is closed.
REQ-016 SHALL implement an FSM with states IDLE, PRESS_DB, PRESSED and REL_DB, plus an 8-bit saturating debounce counter cnt and a 4-bit candidate register cand.
REQ-017 In IDLE, a frame code of 1 to 9 SHALL set cand to that code, set cnt to 1 and move to PRESS_DB; a code of 0 or 15 SHALL keep the FSM in IDLE.
REQ-018 In PRESS_DB, a frame code equal to cand SHALL increment cnt; any other code SHALL clear cnt and return to IDLE.
REQ-019 When cnt reaches DEBOUNCE_SCANS, the FSM SHALL move to PRESSED and load button with cand, and bstate SHALL pulse high for exactly the next cycle.
REQ-020 When DEBOUNCE_SCANS is 1, the first qualifying frame SHALL accept the key directly from IDLE.
REQ-021 In PRESSED, held SHALL be 1; a frame code not equal to button (including 0 and 15) SHALL set cnt to 1 and move to REL_DB.
REQ-022 In REL_DB, a frame code not equal to button SHALL increment cnt; reaching DEBOUNCE_SCANS SHALL return to IDLE with held at 0.
REQ-023 In REL_DB, a frame code equal to button SHALL clear cnt and return to PRESSED with no new bstate pulse.
REQ-024 held SHALL stay 1 throughout REL_DB and SHALL be 0 in IDLE and PRESS_DB.
REQ-025 button SHALL keep its value until the next accepted press and SHALL never be 15.
REQ-026 bstate SHALL never be high on two consecutive cycles, and SHALL pulse at most once per press/release cycle.
REQ-027 Press-to-bstate latency SHALL be at most (DEBOUNCE_SCANS+1)*3*SCAN_TICKS+3 cycles.
REQ-028 Input changes in the middle of a dwell SHALL affect only the sample at the end of that dwell.

Reset
REQ-029 While reset is high, the block SHALL force: FSM in IDLE, cnt=0, cand=0, button=0, bstate=0, held=0, synchronizers=0, scan counter=0, keypad_r1=1, keypad_r2=0, keypad_r3=0.
REQ-030 Reset asserted in any state, including mid-frame or mid-debounce, SHALL abandon the partial frame; scanning SHALL restart at r1 cycle 0 in the first cycle after reset falls.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=3, frame = 12 cycles)
REQ-031 Clean press: close r2/c3 for 60 cycles -> exactly one bstate pulse, button=6, held=1, no earlier than the 3rd complete frame.
REQ-032 Bounce: toggle r1/c1 every 5 cycles for 40 cycles, then hold closed -> no bstate during toggling; one pulse with button=1 only after 3 stable frames.
REQ-033 Release: from PRESSED on key 6, open the switch -> held falls after 3 frames with no bstate pulse; button stays 6; re-closing during REL_DB returns to PRESSED with no pulse.
REQ-034 Multi-key: close r1/c1 and r3/c2 together -> frame code 15, FSM stays IDLE, no bstate; releasing r1/c1 -> one pulse with button=8.
REQ-035 Reset mid-debounce: assert reset for 1 cycle during PRESS_DB of key 9 -> all outputs take their reset values; held key then needs 3 fresh frames before bstate and button=9.
REQ-036 Row walk: with no key closed for 24 cycles -> rows are one-hot in every cycle and follow r1 x4, r2 x4, r3 x4, repeating.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 3x3 keypad row scanner with frame-based press/release debounce
//
// Ports:
//   hwclk                : system clock, rising edge
//   reset                : synchronous active-high reset
//   keypad_r1..r3        : one-hot active-high row drives
//   keypad_c1..c3        : asynchronous active-high column senses
//   button[3:0]          : code of last accepted key (0 = none since reset, 1..9)
//   bstate               : one-cycle strobe per accepted press
//   held                 : high while the accepted key is considered pressed
module keypad_scan_debounce #(
  parameter int SCAN_TICKS     = 12000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       hwclk,
  input  logic       reset,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] button,
  output logic       bstate,
  output logic       held
);

  localparam int             TW        = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0]  TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [7:0]     DB_TARGET = 8'(DEBOUNCE_SCANS);
  localparam bit             DB_ONE    = (DEBOUNCE_SCANS == 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

  logic [2:0]    col_raw;
  logic [2:0]    col_meta;
  logic [2:0]    col_sync;
  logic [TW-1:0] tick;
  logic [2:0]    row_oh;
  logic [2:0]    row1_cols;
  logic [2:0]    row2_cols;
  logic          sample;
  logic          frame_eval;
  logic [8:0]    frame_bits;
  logic [3:0]    hits;
  logic [3:0]    code_one;
  logic [3:0]    frame_code;
  logic          key_valid;
  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    cnt_inc;
  logic [3:0]    cand;

  assign col_raw   = {keypad_c3, keypad_c2, keypad_c1};
  // Rows come straight from a one-hot register so they never glitch.
  assign keypad_r1 = row_oh[0];
  assign keypad_r2 = row_oh[1];
  assign keypad_r3 = row_oh[2];

  assign sample     = (tick == TICK_LAST);
  assign frame_eval = sample & row_oh[2];

  always_ff @(posedge hwclk) begin
    if (reset) begin
      col_meta  <= 3'b000;
      col_sync  <= 3'b000;
      tick      <= '0;
      row_oh    <= 3'b001;
      row1_cols <= 3'b000;
      row2_cols <= 3'b000;
    end else begin
      col_meta <= col_raw;
      col_sync <= col_meta;
      if (sample) begin
        tick   <= '0;
        row_oh <= {row_oh[1:0], row_oh[2]};
        if (row_oh[0]) row1_cols <= col_sync;
        if (row_oh[1]) row2_cols <= col_sync;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // Bit (r-1)*3+(c-1) is the switch at row r, column c; the r3 columns are
  // taken live on the evaluation cycle.
  assign frame_bits = {col_sync, row2_cols, row1_cols};

  always_comb begin
    hits     = 4'd0;
    code_one = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (frame_bits[i]) begin
        hits     = hits + 4'd1;
        code_one = 4'(i + 1);
      end
    end
    if (hits == 4'd0)      frame_code = 4'd0;
    else if (hits == 4'd1) frame_code = code_one;
    else                   frame_code = 4'hF;
  end

  assign key_valid = (frame_code != 4'd0) && (frame_code != 4'hF);
  assign cnt_inc   = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      cand   <= 4'd0;
      button <= 4'd0;
      bstate <= 1'b0;
      held   <= 1'b0;
    end else begin
      bstate <= 1'b0;
      if (frame_eval) begin
        case (state)
          IDLE: begin
            if (key_valid) begin
              cand <= frame_code;
              if (DB_ONE) begin
                state  <= PRESSED;
                button <= frame_code;
                bstate <= 1'b1;
                held   <= 1'b1;
                cnt    <= 8'd0;
              end else begin
                state <= PRESS_DB;
                cnt   <= 8'd1;
              end
            end
          end
          PRESS_DB: begin
            if (frame_code == cand) begin
              if (cnt_inc == DB_TARGET) begin
                state  <= PRESSED;
                button <= cand;
                bstate <= 1'b1;
                held   <= 1'b1;
                cnt    <= 8'd0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              state <= IDLE;
              cnt   <= 8'd0;
            end
          end
          PRESSED: begin
            if (frame_code != button) begin
              if (DB_ONE) begin
                state <= IDLE;
                held  <= 1'b0;
                cnt   <= 8'd0;
              end else begin
                state <= REL_DB;
                cnt   <= 8'd1;
              end
            end
          end
          REL_DB: begin
            if (frame_code != button) begin
              if (cnt_inc == DB_TARGET) begin
                state <= IDLE;
                held  <= 1'b0;
                cnt   <= 8'd0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // Key bounced back closed: resume pressed, no new strobe.
              state <= PRESSED;
              cnt   <= 8'd0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - self-checking bench for keypad_scan_debounce
module tb_keypad_scan_debounce;

  localparam int ST = 4;
  localparam int DB = 3;

  logic       hwclk = 1'b0;
  logic       reset;
  logic       keypad_r1, keypad_r2, keypad_r3;
  logic       keypad_c1, keypad_c2, keypad_c3;
  logic [3:0] button;
  logic       bstate;
  logic       held;
  logic [8:0] keys;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [3:0] exp_q[$];

  keypad_scan_debounce #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .hwclk    (hwclk),
    .reset    (reset),
    .keypad_r1(keypad_r1),
    .keypad_r2(keypad_r2),
    .keypad_r3(keypad_r3),
    .keypad_c1(keypad_c1),
    .keypad_c2(keypad_c2),
    .keypad_c3(keypad_c3),
    .button   (button),
    .bstate   (bstate),
    .held     (held)
  );

  // Switch matrix: keys[(r-1)*3+(c-1)] connects row r to column c.
  assign keypad_c1 = (keys[0] & keypad_r1) | (keys[3] & keypad_r2) | (keys[6] & keypad_r3);
  assign keypad_c2 = (keys[1] & keypad_r1) | (keys[4] & keypad_r2) | (keys[7] & keypad_r3);
  assign keypad_c3 = (keys[2] & keypad_r1) | (keys[5] & keypad_r2) | (keys[8] & keypad_r3);

  always #5 hwclk = ~hwclk;

  typedef struct {
    logic [8:0] keys;
    int         cycles;
    bit         pulse;
    logic [3:0] btn;
    bit         hld;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  // Returns at the negedge inside r1 dwell cycle 0.
  task automatic align_frame();
    logic last_r3;
    last_r3 = keypad_r3;
    for (int k = 0; k < 40; k++) begin
      @(negedge hwclk);
      if (keypad_r1 && last_r3) return;
      last_r3 = keypad_r3;
    end
    total++;
    bad++;
    $display("FAIL align_frame: no r3->r1 transition within 40 cycles");
  endtask

  // Scoreboard consumer: every strobe pops one expected button code.
  initial begin
    logic prev_b;
    prev_b = 1'b0;
    forever begin
      @(negedge hwclk);
      if (bstate) begin
        pulses++;
        check("bstate_not_consecutive", int'(prev_b), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bstate: got button %0d expected no strobe", button);
        end else begin
          check("strobe_button", int'(button), int'(exp_q.pop_front()));
        end
      end
      prev_b = bstate;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int lows;
    int exp_row;

    vecs[0]  = '{9'h020, 60, 1'b1, 4'd6, 1'b1};
    vecs[1]  = '{9'h000, 60, 1'b0, 4'd6, 1'b0};
    vecs[2]  = '{9'h001, 60, 1'b1, 4'd1, 1'b1};
    vecs[3]  = '{9'h000, 60, 1'b0, 4'd1, 1'b0};
    vecs[4]  = '{9'h081, 60, 1'b0, 4'd1, 1'b0};
    vecs[5]  = '{9'h080, 60, 1'b1, 4'd8, 1'b1};
    vecs[6]  = '{9'h000, 60, 1'b0, 4'd8, 1'b0};
    vecs[7]  = '{9'h010, 60, 1'b1, 4'd5, 1'b1};
    vecs[8]  = '{9'h110, 60, 1'b0, 4'd5, 1'b0};
    vecs[9]  = '{9'h100, 60, 1'b1, 4'd9, 1'b1};
    vecs[10] = '{9'h000, 60, 1'b0, 4'd9, 1'b0};

    reset = 1'b1;
    keys  = 9'h000;
    tick(3);
    check("reset_button", int'(button), 0);
    check("reset_bstate", int'(bstate), 0);
    check("reset_held", int'(held), 0);
    check("reset_rows", int'({keypad_r3, keypad_r2, keypad_r1}), 1);

    // Row walk: r1 x4, r2 x4, r3 x4 from the first cycle after reset.
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      exp_row = 1 << ((i / ST) % 3);
      check($sformatf("row_walk_%0d", i), int'({keypad_r3, keypad_r2, keypad_r1}), exp_row);
      @(negedge hwclk);
    end

    for (int v = 0; v < 11; v++) begin
      keys = vecs[v].keys;
      p0 = pulses;
      if (vecs[v].pulse) exp_q.push_back(vecs[v].btn);
      tick(24);
      check($sformatf("vec%0d_no_early_strobe", v), pulses - p0, 0);
      tick(vecs[v].cycles - 24);
      check($sformatf("vec%0d_strobes", v), pulses - p0, vecs[v].pulse ? 1 : 0);
      check($sformatf("vec%0d_button", v), int'(button), int'(vecs[v].btn));
      check($sformatf("vec%0d_held", v), int'(held), int'(vecs[v].hld));
    end

    // Release with a re-close during REL_DB.
    keys = 9'h020;
    exp_q.push_back(4'd6);
    tick(60);
    check("reclose_pressed_held", int'(held), 1);
    align_frame();
    p0 = pulses;
    lows = 0;
    keys = 9'h000;
    for (int i = 0; i < 14; i++) begin
      @(negedge hwclk);
      if (!held) lows++;
    end
    keys = 9'h020;
    for (int i = 0; i < 36; i++) begin
      @(negedge hwclk);
      if (!held) lows++;
    end
    check("reclose_held_never_low", lows, 0);
    check("reclose_no_strobe", pulses - p0, 0);
    check("reclose_button", int'(button), 6);
    keys = 9'h000;
    tick(60);
    check("release_held", int'(held), 0);
    check("release_button", int'(button), 6);
    check("release_no_strobe", pulses - p0, 0);

    // Bounce on key 1 with a 10-cycle period, then hold closed.
    align_frame();
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      keys = 9'h001;
      tick(5);
      keys = 9'h000;
      tick(5);
    end
    check("bounce_no_strobe", pulses - p0, 0);
    keys = 9'h001;
    exp_q.push_back(4'd1);
    tick(24);
    check("bounce_no_early_strobe", pulses - p0, 0);
    tick(36);
    check("bounce_strobes", pulses - p0, 1);
    check("bounce_button", int'(button), 1);
    check("bounce_held", int'(held), 1);
    keys = 9'h000;
    tick(60);
    check("bounce_release_held", int'(held), 0);

    // Reset in the middle of PRESS_DB for key 9.
    align_frame();
    keys = 9'h100;
    tick(30);
    reset = 1'b1;
    @(negedge hwclk);
    check("midreset_button", int'(button), 0);
    check("midreset_bstate", int'(bstate), 0);
    check("midreset_held", int'(held), 0);
    check("midreset_rows", int'({keypad_r3, keypad_r2, keypad_r1}), 1);
    reset = 1'b0;
    p0 = pulses;
    exp_q.push_back(4'd9);
    tick(24);
    check("midreset_no_early_strobe", pulses - p0, 0);
    tick(36);
    check("midreset_strobes", pulses - p0, 1);
    check("midreset_button_after", int'(button), 9);
    check("midreset_held_after", int'(held), 1);
    keys = 9'h000;
    tick(60);
    check("midreset_release_held", int'(held), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
